// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush controller for a 5-stage in-order pipeline: load-use stalls, memory waits, redirects.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_wb_load,
    input  logic [4:0]  ex_wb_rd,
    input  logic        ex_mispredict,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   pending_q, pending_d;

    logic load_use;
    logic mispredict_live;
    logic apply_redirect;
    logic pc_en_core, if_id_en_core, id_ex_en_core, ex_mem_en_core;
    logic if_id_flush_core, id_ex_flush_core;

    always_comb begin
        load_use = ex_wb_load && (ex_wb_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_wb_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_wb_rd)));
    end

    // A redirect cycle leaves a bubble in EX, so any mispredict seen there is stale.
    always_comb begin
        mispredict_live = ex_mispredict && (state_q != ST_REDIRECT);
    end

    always_comb begin
        state_d          = state_q;
        pending_d        = pending_q;
        apply_redirect   = 1'b0;
        pc_en_core       = 1'b1;
        if_id_en_core    = 1'b1;
        id_ex_en_core    = 1'b1;
        ex_mem_en_core   = 1'b1;
        if_id_flush_core = 1'b0;
        id_ex_flush_core = 1'b0;
        if (mem_busy) begin
            pc_en_core     = 1'b0;
            if_id_en_core  = 1'b0;
            id_ex_en_core  = 1'b0;
            ex_mem_en_core = 1'b0;
            pending_d      = pending_q | mispredict_live;
            state_d        = ST_MEM_WAIT;
        end else if (pending_q || mispredict_live) begin
            apply_redirect   = 1'b1;
            pending_d        = 1'b0;
            if_id_en_core    = 1'b0;
            if_id_flush_core = 1'b1;
            id_ex_flush_core = 1'b1;
            state_d          = ST_REDIRECT;
        end else if (load_use && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT))) begin
            pc_en_core       = 1'b0;
            if_id_en_core    = 1'b0;
            id_ex_en_core    = 1'b0;
            id_ex_flush_core = 1'b1;
            state_d          = ST_LD_STALL;
        end else begin
            state_d = ST_RUN;
        end
    end

    // Outputs are held quiet for the whole time reset is asserted.
    always_comb begin
        pc_en       = pc_en_core       & rst_n;
        if_id_en    = if_id_en_core    & rst_n;
        id_ex_en    = id_ex_en_core    & rst_n;
        ex_mem_en   = ex_mem_en_core   & rst_n;
        if_id_flush = if_id_flush_core & rst_n;
        id_ex_flush = id_ex_flush_core & rst_n;
        ctrl_state  = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!pc_en_core && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (apply_redirect && (flush_events_q != 16'hFFFF)) begin
            flush_events_d = flush_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    logic unused_redirect;
    assign unused_redirect = apply_redirect;
    assign stall_cycles    = 32'd0;
    assign flush_events    = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver queues hand-computed expectations per cycle,
// monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] M = 2'd2;
    localparam logic [1:0] D = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_wb_load, ex_mispredict, mem_busy;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_wb_load   (ex_wb_load),
        .ex_wb_rd     (ex_wb_rd),
        .ex_mispredict(ex_mispredict),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  en;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic [15:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Counter model: values visible during the current cycle.
    logic [31:0] m_sc = 32'd0;
    logic [15:0] m_fe = 16'd0;
    bit          prev_rst_n = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_redir = 1'b0;
    bit          preset_req = 1'b0;

    task automatic cyc(input bit rst, input bit busy, input bit mis, input bit load,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2,
                       input logic [3:0] en, input logic [1:0] fl, input logic [1:0] st,
                       input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (prev_rst_n) begin
            if (prev_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (prev_redir && m_fe != 16'hFFFF)      m_fe = m_fe + 16'd1;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (preset_req) begin
            dut.stall_cycles_q = 32'hFFFF_FFFD;
            m_sc = 32'hFFFF_FFFD;
            preset_req = 1'b0;
        end
`endif
        rst_n         = rst;
        mem_busy      = busy;
        ex_mispredict = mis;
        ex_wb_load    = load;
        ex_wb_rd      = rd;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_uses_rs1   = u1;
        id_uses_rs2   = u2;
        if (!rst) begin
            m_sc = 32'd0;
            m_fe = 16'd0;
        end
        e.name = name;
        e.en   = en;
        e.fl   = fl;
        e.st   = st;
`ifdef HAZARD_PERF_CNT_EN
        e.sc   = m_sc;
        e.fe   = m_fe;
`else
        e.sc   = 32'd0;
        e.fe   = 16'd0;
`endif
        exp_q.push_back(e);
        prev_rst_n = rst;
        prev_stall = !en[3];
        prev_redir = (fl == 2'b11);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act_en;
            logic [1:0] act_fl;
            e      = exp_q.pop_front();
            act_en = {pc_en, if_id_en, id_ex_en, ex_mem_en};
            act_fl = {if_id_flush, id_ex_flush};
            $display("txn %s en=%b fl=%b st=%0d sc=%h fe=%h", e.name, act_en, act_fl,
                     ctrl_state, stall_cycles, flush_events);
            checks++;
            if ({act_en, act_fl} !== {e.en, e.fl}) begin
                errors++;
                $display("FAIL %s outputs: got en=%b fl=%b want en=%b fl=%b",
                         e.name, act_en, act_fl, e.en, e.fl);
            end
            checks++;
            if (ctrl_state !== e.st) begin
                errors++;
                $display("FAIL %s state: got %0d want %0d", e.name, ctrl_state, e.st);
            end
            checks++;
            if (stall_cycles !== e.sc || flush_events !== e.fe) begin
                errors++;
                $display("FAIL %s counters: got sc=%h fe=%h want sc=%h fe=%h",
                         e.name, stall_cycles, flush_events, e.sc, e.fe);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0; mem_busy = 1'b0; ex_mispredict = 1'b0; ex_wb_load = 1'b0;
        ex_wb_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;

        cyc(0,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"reset");
        cyc(0,1,1,1,5'd5,5'd5,5'd5,1,1, 4'b0000,2'b00,R,"reset_busy_in");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"idle");
        cyc(1,0,0,1,5'd5,5'd0,5'd5,0,1, 4'b0001,2'b01,R,"ld_use_rs2");
        cyc(1,0,0,1,5'd5,5'd0,5'd5,0,1, 4'b1111,2'b00,L,"ld_stall_no_redetect");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"after_ld");
        cyc(1,0,0,1,5'd0,5'd0,5'd5,0,1, 4'b1111,2'b00,R,"rd0_rs2_5");
        cyc(1,0,0,1,5'd0,5'd0,5'd0,1,1, 4'b1111,2'b00,R,"rd0_rs_0");
        cyc(1,0,0,1,5'd7,5'd7,5'd0,0,1, 4'b1111,2'b00,R,"rs1_unused");
        cyc(1,0,0,1,5'd7,5'd7,5'd0,1,0, 4'b0001,2'b01,R,"ld_use_rs1");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,L,"ld_stall");
        cyc(1,0,0,0,5'd3,5'd0,5'd3,0,1, 4'b1111,2'b00,R,"not_load");
        cyc(1,0,1,1,5'd5,5'd0,5'd5,0,1, 4'b1011,2'b11,R,"mis_and_ld");
        cyc(1,0,1,1,5'd5,5'd0,5'd5,0,1, 4'b1111,2'b00,D,"redirect_ignores");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"after_redirect");
        cyc(1,1,1,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"busy1_mis");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"busy2");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"busy3");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1011,2'b11,M,"pending_redirect");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,D,"redirect_cycle");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"run_again");
        cyc(1,1,0,1,5'd5,5'd0,5'd5,0,1, 4'b0000,2'b00,R,"busy_over_ld");
        cyc(1,0,0,1,5'd5,5'd0,5'd5,0,1, 4'b0001,2'b01,M,"exit_wait_ld");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,L,"ld_stall_after_wait");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"busy_plain");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,M,"exit_wait_clean");
        cyc(1,0,1,0,5'd0,5'd0,5'd0,0,0, 4'b1011,2'b11,R,"mis_plain");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,D,"redirect_plain");
        cyc(1,1,1,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"busy_mis_r");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"busy_r");
        cyc(0,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"reset_in_wait");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"no_redirect_after_rst");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,R,"idle_end");
`ifdef HAZARD_PERF_CNT_EN
        preset_req = 1'b1;
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,R,"sat_busy1");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"sat_busy2");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"sat_busy3");
        cyc(1,1,0,0,5'd0,5'd0,5'd0,0,0, 4'b0000,2'b00,M,"sat_busy4");
        cyc(1,0,0,0,5'd0,5'd0,5'd0,0,0, 4'b1111,2'b00,M,"sat_hold");
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
